// File: rtl/max7219_rx_if.sv
// max7219_rx_if: bundles the serial link, the write-report bus and the
// display-state outputs of the MAX7219 receiver.
//   master : drives CS/CLK/Din (the driver side, or a testbench)
//   slave  : the receiver; drives DOUT, write report, register and scan outputs
interface max7219_rx_if;
    // serial link
    logic       CS;
    logic       CLK;
    logic       Din;
    logic       DOUT;
    // write report
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;
    // register file views
    logic [3:0] intensity;
    logic [2:0] scan_limit;
    logic       shutdown_n;
    logic       test;
    logic [7:0] decode_mode;
    // digit scanner
    logic [7:0] dig_sel;
    logic [7:0] seg;

    modport master (
        output CS, CLK, Din,
        input  DOUT, wr_valid, wr_addr, wr_data, frame_err,
        input  intensity, scan_limit, shutdown_n, test, decode_mode,
        input  dig_sel, seg
    );

    modport slave (
        input  CS, CLK, Din,
        output DOUT, wr_valid, wr_addr, wr_data, frame_err,
        output intensity, scan_limit, shutdown_n, test, decode_mode,
        output dig_sel, seg
    );
endinterface

// File: rtl/max7219_rx.sv
// max7219_rx: MAX7219-compatible serial receiver and display-state model.
// Oversamples the 3-wire link (CS/LOAD, CLK, Din) in the sys_clk domain,
// decodes 16-bit register writes into the MAX7219 register file, drives a
// cascade DOUT and a multiplexed digit scanner.
//
// Ports:
//   sys_clk  - system clock, all logic on its rising edge
//   _rst     - asynchronous active-low reset
//   bus      - max7219_rx_if.slave: CS/CLK/Din in; DOUT, wr_valid/wr_addr/
//              wr_data/frame_err, intensity/scan_limit/shutdown_n/test/
//              decode_mode, dig_sel/seg out
//
// Parameters:
//   SYNC_STAGES - synchronizer depth on CS/CLK/Din (>= 2)
//   SCAN_DIV    - sys_clk cycles per digit scan slot (>= 2)
//
// Optional feature macro: MAX7219_RX_CODEB_EN enables Code-B font decoding
// of digits whose decode_mode bit is set. Without it seg is always raw.
module max7219_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SCAN_DIV    = 50000
) (
    input  logic            sys_clk,
    input  logic            _rst,
    max7219_rx_if.slave     bus
);

    localparam int unsigned CNT_W      = 5;
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned PRE_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] din_sync;
    logic                   cs_d;
    logic                   clk_d;

    always_ff @(posedge sys_clk or negedge _rst) begin
        if (!_rst) begin
            cs_sync  <= '1;
            clk_sync <= '0;
            din_sync <= '0;
            cs_d     <= 1'b1;
            clk_d    <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0],  bus.CS};
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.CLK};
            din_sync <= {din_sync[SYNC_STAGES-2:0], bus.Din};
            cs_d     <= cs_sync[SYNC_STAGES-1];
            clk_d    <= clk_sync[SYNC_STAGES-1];
        end
    end

    logic cs_s;
    logic clk_s;
    logic din_s;
    logic cs_fall;
    logic cs_rise;
    logic clk_rise;
    logic clk_fall;

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign din_s    = din_sync[SYNC_STAGES-1];
    assign cs_fall  =  cs_d & ~cs_s;
    assign cs_rise  = ~cs_d &  cs_s;
    assign clk_rise = ~clk_d &  clk_s;
    assign clk_fall =  clk_d & ~clk_s;

    // ------------------------------------------------------------------
    // Frame shifting; a CLK rise coinciding with the CS rise still belongs
    // to the frame, so the latch below looks at the post-shift values.
    // ------------------------------------------------------------------
    logic [15:0]      shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             out_bit;
    logic             shift_en;
    logic [15:0]      shreg_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             frame_ok;
    logic             frame_bad;
    logic [3:0]       addr_nx;
    logic [7:0]       data_nx;

    assign shift_en = clk_rise & (~cs_s | cs_rise);

    always_comb begin
        shreg_nx = shreg;
        cnt_nx   = bit_cnt;
        if (shift_en) begin
            shreg_nx = {shreg[14:0], din_s};
        end
        if (cs_fall) begin
            cnt_nx = '0;
        end else if (shift_en && (bit_cnt < CNT_W'(FRAME_BITS))) begin
            cnt_nx = bit_cnt + CNT_W'(1);
        end
    end

    assign frame_ok  = cs_rise & (cnt_nx >= CNT_W'(FRAME_BITS));
    assign frame_bad = cs_rise & (cnt_nx <  CNT_W'(FRAME_BITS));
    assign addr_nx   = shreg_nx[11:8];
    assign data_nx   = shreg_nx[7:0];

    always_ff @(posedge sys_clk or negedge _rst) begin
        if (!_rst) begin
            shreg         <= '0;
            bit_cnt       <= '0;
            out_bit       <= 1'b0;
            bus.DOUT      <= 1'b0;
            bus.wr_valid  <= 1'b0;
            bus.wr_addr   <= '0;
            bus.wr_data   <= '0;
            bus.frame_err <= 1'b0;
        end else begin
            shreg         <= shreg_nx;
            bit_cnt       <= cnt_nx;
            bus.wr_valid  <= frame_ok;
            bus.frame_err <= frame_bad;
            // bit leaving the top of the shift register, shown on the next fall
            if (shift_en) begin
                out_bit <= shreg[15];
            end
            if (clk_fall && !cs_s) begin
                bus.DOUT <= out_bit;
            end
            if (frame_ok) begin
                bus.wr_addr <= addr_nx;
                bus.wr_data <= data_nx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file; writes become visible together with wr_valid
    // ------------------------------------------------------------------
    logic [7:0] digit [8];

    always_ff @(posedge sys_clk or negedge _rst) begin
        if (!_rst) begin
            for (int i = 0; i < 8; i++) begin
                digit[i] <= '0;
            end
            bus.decode_mode <= '0;
            bus.intensity   <= '0;
            bus.scan_limit  <= '0;
            bus.shutdown_n  <= 1'b0;
            bus.test        <= 1'b0;
        end else if (frame_ok) begin
            case (addr_nx)
                4'h1, 4'h2, 4'h3, 4'h4,
                4'h5, 4'h6, 4'h7, 4'h8: digit[IDX_W'(addr_nx - 4'd1)] <= data_nx;
                4'h9:    bus.decode_mode <= data_nx;
                4'hA:    bus.intensity   <= data_nx[3:0];
                4'hB:    bus.scan_limit  <= data_nx[2:0];
                4'hC:    bus.shutdown_n  <= data_nx[0];
                4'hF:    bus.test        <= data_nx[0];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scan prescaler and digit index
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] presc;
    logic [IDX_W-1:0] dig_idx;
    logic             slot_wrap;

    assign slot_wrap = (presc == PRE_W'(SCAN_DIV - 1));

    always_ff @(posedge sys_clk or negedge _rst) begin
        if (!_rst) begin
            presc   <= '0;
            dig_idx <= '0;
        end else if (slot_wrap) begin
            presc <= '0;
            // ">=" also catches an index stranded above a lowered scan_limit
            if (dig_idx >= bus.scan_limit) begin
                dig_idx <= '0;
            end else begin
                dig_idx <= dig_idx + IDX_W'(1);
            end
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Segment source for the selected digit
    // ------------------------------------------------------------------
    logic [7:0] digit_raw;
    logic [7:0] digit_seg;

    assign digit_raw = digit[dig_idx];

`ifdef MAX7219_RX_CODEB_EN
    // Code-B font, segments A..G in bits [6:0]
    function automatic logic [6:0] code_b(input logic [3:0] nib);
        logic [6:0] f;
        case (nib)
            4'h0:    f = 7'h7E;
            4'h1:    f = 7'h30;
            4'h2:    f = 7'h6D;
            4'h3:    f = 7'h79;
            4'h4:    f = 7'h33;
            4'h5:    f = 7'h5B;
            4'h6:    f = 7'h5F;
            4'h7:    f = 7'h70;
            4'h8:    f = 7'h7F;
            4'h9:    f = 7'h7B;
            4'hA:    f = 7'h01;  // '-'
            4'hB:    f = 7'h4F;  // 'E'
            4'hC:    f = 7'h37;  // 'H'
            4'hD:    f = 7'h0E;  // 'L'
            4'hE:    f = 7'h67;  // 'P'
            default: f = 7'h00;  // blank
        endcase
        return f;
    endfunction

    always_comb begin
        digit_seg = digit_raw;
        if (bus.decode_mode[dig_idx]) begin
            digit_seg = {digit_raw[7], code_b(digit_raw[3:0])};
        end
    end
`else
    assign digit_seg = digit_raw;
`endif

    // ------------------------------------------------------------------
    // Scanner outputs: test overrides shutdown, shutdown blanks everything
    // ------------------------------------------------------------------
    logic [7:0] dig_sel_c;
    logic [7:0] seg_c;
    logic [7:0] sel_onehot_n;

    assign sel_onehot_n = ~(8'h01 << dig_idx);

    always_comb begin
        dig_sel_c = 8'hFF;
        seg_c     = 8'h00;
        if (bus.test) begin
            dig_sel_c = sel_onehot_n;
            seg_c     = 8'hFF;
        end else if (bus.shutdown_n) begin
            dig_sel_c = sel_onehot_n;
            seg_c     = digit_seg;
        end
    end

    always_ff @(posedge sys_clk or negedge _rst) begin
        if (!_rst) begin
            bus.dig_sel <= 8'hFF;
            bus.seg     <= 8'h00;
        end else begin
            bus.dig_sel <= dig_sel_c;
            bus.seg     <= seg_c;
        end
    end

endmodule

// File: tb/tb_max7219_rx.sv
// tb_max7219_rx: directed self-checking bench for max7219_rx.
// Bit-bangs CS/CLK/Din slowly relative to sys_clk, counts wr_valid and
// frame_err pulses, and compares outputs against hand-computed values.
module tb_max7219_rx;

    localparam int unsigned SCAN_DIV = 16;

    logic sys_clk;
    logic _rst;

    max7219_rx_if bus();

    max7219_rx #(
        .SYNC_STAGES (2),
        .SCAN_DIV    (SCAN_DIV)
    ) dut (
        .sys_clk (sys_clk),
        ._rst    (_rst),
        .bus     (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          wv_cnt = 0;
    int          fe_cnt = 0;
    int          wv0;
    int          fe0;
    logic [31:0] dout_bits;
    logic [7:0]  exp_seg;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // pulse counters, sampled mid-cycle
    always @(negedge sys_clk) begin
        if (bus.wr_valid  === 1'b1) wv_cnt++;
        if (bus.frame_err === 1'b1) fe_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic shift_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.Din = val[i];
            tick(3);
            bus.CLK = 1'b1;
            tick(4);
            bus.CLK = 1'b0;
            tick(4);
            dout_bits = {dout_bits[30:0], bus.DOUT};
        end
    endtask

    task automatic send(input logic [31:0] val, input int n);
        bus.CS = 1'b0;
        tick(4);
        shift_bits(val, n);
        tick(2);
        bus.CS = 1'b1;
        tick(8);
    endtask

    // align to the first cycle of scan slot 0
    task automatic wait_slot0(input string tag);
        int k;
        k = 0;
        while (bus.dig_sel == 8'hFE && k < 200) begin
            tick(1);
            k++;
        end
        while (bus.dig_sel != 8'hFE && k < 400) begin
            tick(1);
            k++;
        end
        check(tag, 32'(k < 400), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"},     32'(bus.DOUT),        32'd0);
        check({tag, "_wr_valid"}, 32'(bus.wr_valid),    32'd0);
        check({tag, "_wr_addr"},  32'(bus.wr_addr),     32'd0);
        check({tag, "_wr_data"},  32'(bus.wr_data),     32'd0);
        check({tag, "_ferr"},     32'(bus.frame_err),   32'd0);
        check({tag, "_intens"},   32'(bus.intensity),   32'd0);
        check({tag, "_limit"},    32'(bus.scan_limit),  32'd0);
        check({tag, "_shdn"},     32'(bus.shutdown_n),  32'd0);
        check({tag, "_test"},     32'(bus.test),        32'd0);
        check({tag, "_decode"},   32'(bus.decode_mode), 32'd0);
        check({tag, "_dig_sel"},  32'(bus.dig_sel),     32'hFF);
        check({tag, "_seg"},      32'(bus.seg),         32'd0);
    endtask

    initial begin
        dout_bits = '0;
        bus.CS  = 1'b1;
        bus.CLK = 1'b0;
        bus.Din = 1'b0;
        _rst    = 1'b0;
        tick(5);
        check_reset_outputs("rst");
        _rst = 1'b1;
        tick(5);

        // shutdown off
        wv0 = wv_cnt;
        send(32'h0C01, 16);
        check("c01_wv_pulses", 32'(wv_cnt - wv0), 32'd1);
        check("c01_addr",      32'(bus.wr_addr),     32'hC);
        check("c01_data",      32'(bus.wr_data),     32'h01);
        check("c01_shdn",      32'(bus.shutdown_n),  32'd1);
        check("c01_intens",    32'(bus.intensity),   32'd0);
        check("c01_limit",     32'(bus.scan_limit),  32'd0);
        check("c01_test",      32'(bus.test),        32'd0);
        check("c01_decode",    32'(bus.decode_mode), 32'd0);
        check("c01_ferr",      32'(fe_cnt),          32'd0);
        check("c01_dig_sel",   32'(bus.dig_sel),     32'hFE);
        check("c01_seg",       32'(bus.seg),         32'h00);

        // scanning 8 digits
        send(32'h01AA, 16);
        send(32'h0B07, 16);
        send(32'h0C01, 16);
        check("scan_limit7", 32'(bus.scan_limit), 32'd7);
        wait_slot0("scan_find0");
        check("scan0_sel", 32'(bus.dig_sel), 32'hFE);
        check("scan0_seg", 32'(bus.seg),     32'hAA);
        tick(SCAN_DIV);
        check("scan1_sel", 32'(bus.dig_sel), 32'hFD);
        check("scan1_seg", 32'(bus.seg),     32'h00);
        tick(6 * SCAN_DIV);
        check("scan7_sel", 32'(bus.dig_sel), 32'h7F);
        tick(SCAN_DIV);
        check("wrap_sel",  32'(bus.dig_sel), 32'hFE);
        check("wrap_seg",  32'(bus.seg),     32'hAA);

        // over-length frames: last 16 bits win, head bits pass to DOUT
        send(32'hF0A05, 20);
        check("long1_intens", 32'(bus.intensity),  32'd5);
        check("long1_addr",   32'(bus.wr_addr),    32'hA);
        check("long1_data",   32'(bus.wr_data),    32'h05);
        check("long1_dout",   32'(dout_bits[3:0]), 32'hF);
        send(32'hA0A03, 20);
        check("long2_intens", 32'(bus.intensity),  32'd3);
        check("long2_dout",   32'(dout_bits[3:0]), 32'hA);

        // short frame
        wv0 = wv_cnt;
        fe0 = fe_cnt;
        send(32'h2AA, 10);
        check("short_ferr",   32'(fe_cnt - fe0),    32'd1);
        check("short_wv",     32'(wv_cnt - wv0),    32'd0);
        check("short_intens", 32'(bus.intensity),   32'd3);
        check("short_data",   32'(bus.wr_data),     32'h03);
        check("short_limit",  32'(bus.scan_limit),  32'd7);

        // reset in the middle of a frame
        fe0 = fe_cnt;
        wv0 = wv_cnt;
        bus.CS = 1'b0;
        tick(4);
        shift_bits(32'h35, 6);
        _rst = 1'b0;
        tick(2);
        bus.CS = 1'b1;
        tick(3);
        check_reset_outputs("midrst");
        _rst = 1'b1;
        tick(10);
        check("midrst_ferr", 32'(fe_cnt - fe0), 32'd0);
        check("midrst_wv",   32'(wv_cnt - wv0), 32'd0);

        // display test overrides shutdown
        send(32'h0B07, 16);
        send(32'h0F01, 16);
        check("test_on",   32'(bus.test),       32'd1);
        check("test_shdn", 32'(bus.shutdown_n), 32'd0);
        wait_slot0("test_find0");
        check("test_sel0", 32'(bus.dig_sel), 32'hFE);
        for (int s = 0; s < 8; s++) begin
            check($sformatf("test_seg_slot%0d", s), 32'(bus.seg), 32'hFF);
            tick(SCAN_DIV);
        end
        send(32'h0F00, 16);
        check("test_off_sel", 32'(bus.dig_sel), 32'hFF);
        check("test_off_seg", 32'(bus.seg),     32'h00);

        // Code-B decode of digit 0
        send(32'h09FF, 16);
        send(32'h0185, 16);
        send(32'h0C01, 16);
        check("dec_mode", 32'(bus.decode_mode), 32'hFF);
        wait_slot0("dec_find0");
`ifdef MAX7219_RX_CODEB_EN
        exp_seg = 8'hDB;
`else
        exp_seg = 8'h85;
`endif
        check("dec_sel", 32'(bus.dig_sel), 32'hFE);
        check("dec_seg", 32'(bus.seg),     32'(exp_seg));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
